// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the HI/LO multiply/divide unit.
//   state_t        : IDLE / RUN / FIN sequencer states
//   OP_MULT/OP_DIV : op_div encodings
//   OP_UNSIGNED/OP_SIGNED : op_signed encodings
//   DIV0_QUOTIENT  : quotient returned on divide by zero (all ones, sliced to WIDTH)
package muldiv_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  localparam logic OP_MULT     = 1'b0;
  localparam logic OP_DIV      = 1'b1;
  localparam logic OP_UNSIGNED = 1'b0;
  localparam logic OP_SIGNED   = 1'b1;

  localparam logic [63:0] DIV0_QUOTIENT = '1;
endpackage

// File: rtl/muldiv_signfix.sv
// muldiv_signfix: combinational sign handling shared by multiply and divide.
//   Entry : i_a/i_b -> o_abs_a/o_abs_b (magnitudes when i_signed).
//   Exit  : i_res = {upper, lower} of the unsigned core result.
//           multiply (i_div=0): whole 2*WIDTH product negated when i_neg_res.
//           divide   (i_div=1): lower (quotient) negated when i_neg_res,
//                               upper (remainder) negated when i_neg_rem.
module muldiv_signfix
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               i_signed,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic [WIDTH-1:0]   o_abs_a,
  output logic [WIDTH-1:0]   o_abs_b,
  input  logic               i_div,
  input  logic               i_neg_res,
  input  logic               i_neg_rem,
  input  logic [2*WIDTH-1:0] i_res,
  output logic [2*WIDTH-1:0] o_res
);
  // Most-negative input maps onto itself, which is the correct unsigned magnitude.
  assign o_abs_a = (i_signed == OP_SIGNED && i_a[WIDTH-1]) ? -i_a : i_a;
  assign o_abs_b = (i_signed == OP_SIGNED && i_b[WIDTH-1]) ? -i_b : i_b;

  always_comb begin
    o_res = i_res;
    if (i_div) begin
      if (i_neg_res) o_res[WIDTH-1:0]       = -i_res[WIDTH-1:0];
      if (i_neg_rem) o_res[2*WIDTH-1:WIDTH] = -i_res[2*WIDTH-1:WIDTH];
    end else if (i_neg_res) begin
      o_res = -i_res;
    end
  end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply/divide unit owning HI/LO.
//   clk, reset (sync, active high)
//   start, op_signed, op_div, a, b : operation request (taken only in IDLE)
//   hi_we, lo_we, wdata            : mthi/mtlo writes (IDLE and start=0 only)
//   busy, done                     : stall / one-cycle completion pulse
//   hi, lo                         : HI/LO registers
// Build option: define MULDIV_DIVIDE_EN to compile in the divide datapath;
// without it, divide requests are ignored.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op_signed,
  input  logic             op_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  state_t             r_state, w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_d;      // multiplicand / divisor
  logic [WIDTH-1:0]   r_q;      // multiplier -> product low / dividend -> quotient
  logic [WIDTH-1:0]   r_r;      // product high / partial remainder
  logic               r_neg_res;
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic               r_done;

  logic               w_op_ok, w_accept;
  logic               w_div, w_neg_rem;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_lo_res;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_fix;

`ifdef MULDIV_DIVIDE_EN
  logic               r_div, r_neg_rem, r_div0;
  logic [WIDTH:0]     w_shl;
  logic               w_ge;
  logic [WIDTH-1:0]   w_sub;

  assign w_op_ok   = 1'b1;
  assign w_div     = r_div;
  assign w_neg_rem = r_neg_rem;
  // Restoring step; the trial difference always fits WIDTH bits when it is kept.
  assign w_shl     = {r_r, r_q[WIDTH-1]};
  assign w_ge      = (w_shl >= {1'b0, r_d});
  assign w_sub     = w_shl[WIDTH-1:0] - r_d;
  // Divide by zero: the core already leaves |a| as remainder, so only the
  // quotient needs overriding (the sign fix then restores hi = a).
  assign w_lo_res  = r_div0 ? DIV0_QUOTIENT[WIDTH-1:0] : w_fix[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div     <= 1'b0;
      r_neg_rem <= 1'b0;
      r_div0    <= 1'b0;
    end else if (w_accept) begin
      r_div     <= op_div;
      r_neg_rem <= op_signed & a[WIDTH-1];
      r_div0    <= (op_div == OP_DIV) && (b == '0);
    end
  end
`else
  assign w_op_ok   = (op_div == OP_MULT);
  assign w_div     = 1'b0;
  assign w_neg_rem = 1'b0;
  assign w_lo_res  = w_fix[WIDTH-1:0];
`endif

  assign w_accept  = (r_state == IDLE) && start && w_op_ok;
  assign w_mul_sum = {1'b0, r_r} + {1'b0, (r_q[0] ? r_d : '0)};

  muldiv_signfix #(.WIDTH(WIDTH)) u_signfix (
    .i_signed (op_signed),
    .i_a      (a),
    .i_b      (b),
    .o_abs_a  (w_abs_a),
    .o_abs_b  (w_abs_b),
    .i_div    (w_div),
    .i_neg_res(r_neg_res),
    .i_neg_rem(w_neg_rem),
    .i_res    ({r_r, r_q}),
    .o_res    (w_fix)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = RUN;
      RUN:     if (r_cnt == CNT_W'(WIDTH-1)) w_next = FIN;
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_d       <= '0;
      r_q       <= '0;
      r_r       <= '0;
      r_neg_res <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= (r_state == FIN);
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_cnt     <= '0;
            r_r       <= '0;
            r_neg_res <= op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef MULDIV_DIVIDE_EN
            if (op_div == OP_DIV) begin
              r_d <= w_abs_b;
              r_q <= w_abs_a;
            end else
`endif
            begin
              r_d <= w_abs_a;
              r_q <= w_abs_b;
            end
          end else if (!start) begin
            if (hi_we) r_hi <= wdata;
            if (lo_we) r_lo <= wdata;
          end
        end
        RUN: begin
          r_cnt <= r_cnt + CNT_W'(1);
`ifdef MULDIV_DIVIDE_EN
          if (r_div) begin
            r_r <= w_ge ? w_sub : w_shl[WIDTH-1:0];
            r_q <= {r_q[WIDTH-2:0], w_ge};
          end else
`endif
          begin
            r_r <= w_mul_sum[WIDTH:1];
            r_q <= {w_mul_sum[0], r_q[WIDTH-1:1]};
          end
        end
        FIN: begin
          r_hi <= w_fix[2*WIDTH-1:WIDTH];
          r_lo <= w_lo_res;
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != IDLE);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;
endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        reset, start, op_signed, op_div, hi_we, lo_we;
  logic [31:0] a, b, wdata;
  logic        busy, done;
  logic [31:0] hi, lo;
  int          n_chk = 0;
  int          n_err = 0;
  int          lat, nbusy, ndone;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op_signed(op_signed),
    .op_div(op_div), .a(a), .b(b), .hi_we(hi_we), .lo_we(lo_we),
    .wdata(wdata), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op in the current cycle and run until done (bounded).
  // inj_start/inj_we: cycle index at which to inject a start / mthi while busy.
  task automatic run_op(input logic sg, input logic dv, input logic [31:0] oa,
                        input logic [31:0] ob, input int inj_start, input int inj_we,
                        output int o_lat, output int o_nbusy);
    logic [31:0] h0;
    h0 = hi;
    start = 1'b1; op_signed = sg; op_div = dv; a = oa; b = ob;
    tick();
    start = 1'b0;
    o_lat = 1; o_nbusy = 0;
    while (!done && o_lat < 100) begin
      if (busy) o_nbusy++;
      if (o_lat == inj_we + 1) chk("hi_we_while_busy", hi, h0);
      if (o_lat == inj_start) begin start = 1'b1; a = 32'd9; b = 32'd9; end
      if (o_lat == inj_we) begin hi_we = 1'b1; wdata = 32'h1234; end
      tick();
      start = 1'b0; hi_we = 1'b0;
      o_lat++;
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op_signed = 1'b0; op_div = 1'b0;
    hi_we = 1'b0; lo_we = 1'b0; a = '0; b = '0; wdata = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_hi", hi, 0); chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0);

    // MULTU max*max: busy 33 cycles, done at cycle 34
    run_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, lat, nbusy);
    chk("multu_lat", lat, 34); chk("multu_busy_cycles", nbusy, 33);
    chk("multu_busy_at_done", busy, 0);
    chk("multu_hi", hi, 32'hFFFF_FFFE); chk("multu_lo", lo, 32'h0000_0001);
    tick();
    chk("done_one_cycle", done, 0);

    // MULT -3*5, then MULTU 7*6 started in the done cycle
    run_op(1'b1, 1'b0, 32'hFFFF_FFFD, 32'd5, -1, -1, lat, nbusy);
    chk("mult_neg_hi", hi, 32'hFFFF_FFFF); chk("mult_neg_lo", lo, 32'hFFFF_FFF1);
    run_op(1'b0, 1'b0, 32'd7, 32'd6, -1, -1, lat, nbusy);
    chk("b2b_lat", lat, 34);
    chk("b2b_hi", hi, 0); chk("b2b_lo", lo, 42);

    // start at cycle 5 and mthi at cycle 7 while busy are both ignored
    run_op(1'b0, 1'b0, 32'd1000, 32'd3, 5, 7, lat, nbusy);
    chk("ignore_start_lat", lat, 34);
    chk("ignore_start_lo", lo, 3000); chk("ignore_start_hi", hi, 0);
    tick();

    // mthi in IDLE
    hi_we = 1'b1; wdata = 32'h1234;
    tick();
    hi_we = 1'b0;
    chk("mthi_idle", hi, 32'h1234); chk("mthi_lo_kept", lo, 3000);
    // mtlo alongside start: start wins, result lands
    lo_we = 1'b1; wdata = 32'h55;
    run_op(1'b0, 1'b0, 32'd2, 32'd2, -1, -1, lat, nbusy);
    lo_we = 1'b0;
    chk("start_wins_lo", lo, 4); chk("start_wins_hi", hi, 0);
    tick();
    hi_we = 1'b1; wdata = 32'h1234;
    tick();
    hi_we = 1'b0;

`ifdef MULDIV_DIVIDE_EN
    run_op(1'b0, 1'b1, 32'd100, 32'd7, -1, -1, lat, nbusy);
    chk("divu_lat", lat, 34);
    chk("divu_lo", lo, 14); chk("divu_hi", hi, 2);
    run_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, -1, -1, lat, nbusy);
    chk("div_neg_lo", lo, 32'hFFFF_FFFD); chk("div_neg_hi", hi, 32'hFFFF_FFFF);
    run_op(1'b0, 1'b1, 32'd5, 32'd0, -1, -1, lat, nbusy);
    chk("divu0_lo", lo, 32'hFFFF_FFFF); chk("divu0_hi", hi, 5);
    run_op(1'b1, 1'b1, 32'hFFFF_FFFB, 32'd0, -1, -1, lat, nbusy);
    chk("div0_neg_lo", lo, 32'hFFFF_FFFF); chk("div0_neg_hi", hi, 32'hFFFF_FFFB);
    run_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, lat, nbusy);
    chk("div_ovf_lo", lo, 32'h8000_0000); chk("div_ovf_hi", hi, 0);
    tick();
    hi_we = 1'b1; wdata = 32'h1234;
    tick();
    hi_we = 1'b0;
`else
    // divide request is ignored when the divider is not built
    start = 1'b1; op_signed = 1'b0; op_div = 1'b1; a = 32'd100; b = 32'd7;
    tick();
    start = 1'b0; op_div = 1'b0;
    chk("nodiv_busy", busy, 0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) ndone++;
      tick();
    end
    chk("nodiv_no_activity", ndone, 0);
    chk("nodiv_hi", hi, 32'h1234); chk("nodiv_lo", lo, 4);
`endif

    // reset at cycle 10 of a MULT aborts with no done pulse
    start = 1'b1; op_signed = 1'b1; op_div = 1'b0; a = 32'hFFFF_FFFD; b = 32'd5;
    tick();
    start = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    chk("pre_rst_busy", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", busy, 0); chk("abort_hi", hi, 0); chk("abort_lo", lo, 0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) ndone++;
      tick();
    end
    chk("abort_no_done", ndone, 0);
    run_op(1'b0, 1'b0, 32'd7, 32'd6, -1, -1, lat, nbusy);
    chk("post_rst_lat", lat, 34);
    chk("post_rst_lo", lo, 42); chk("post_rst_hi", hi, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle multiply/divide unit that owns the HI/LO register pair for the single-cycle MIPS datapath.
- Sits beside the ALU, taking the same srca/srcb operands from the register file.
- Its hi/lo outputs feed the result mux for mfhi/mflo, replacing the combinational multiply currently inside the ALU.
- Iterative radix-2 algorithm, one bit per clock. A start/busy/done handshake lets the control unit stall the PC.

Parameters:
- WIDTH, 32, operand width and HI/LO width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled only when not busy.
- op_signed  input  1  1 = signed (MULT/DIV), 0 = unsigned (MULTU/DIVU).
- op_div  input  1  1 = divide, 0 = multiply.
- a  input  WIDTH  operand A (rs); dividend or multiplicand.
- b  input  WIDTH  operand B (rt); divisor or multiplier.
- hi_we  input  1  mthi write strobe.
- lo_we  input  1  mtlo write strobe.
- wdata  input  WIDTH  data for mthi/mtlo.
- busy  output  1  operation in progress; control must stall.
- done  output  1  one-cycle pulse; hi/lo hold the new result.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- One clock domain (clk); reset is synchronous and active-high. The reset port is named reset.
- Reset values: state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0.
- Reset mid-operation aborts the operation; no done pulse is produced.
- States and transitions:
  - IDLE: start=1 latches |a|, |b|, op_signed, op_div and the result sign, clears the accumulator, counter=0, goes to RUN.
  - RUN: one iteration per cycle. Multiply is shift-add; divide is restoring shift-subtract. At counter==WIDTH-1, go to FIN.
  - FIN: apply sign fix, write hi/lo, go to IDLE. done=1 during the cycle after this edge.
- Latency: start sampled at edge E0; hi/lo are updated at edge E(WIDTH+1); done is high for exactly the cycle following that edge (33 cycles at the default width).
- busy is high from the cycle after E0 through the FIN cycle, and low while done is high.
- start while busy: ignored (no queue).
- start in the done cycle: accepted, so operations can run back-to-back.
- Multiply result: {hi,lo} = full 2·WIDTH product. In signed mode the product is negated when sign(a)^sign(b).
- Divide result: lo = quotient, truncated toward zero; hi = remainder, carrying the sign of the dividend.
- Divide by zero (b==0): lo=all ones, hi=a. No trap.
- Signed overflow (a=0x80000000, b=-1): lo=0x80000000, hi=0.
- mthi/mtlo: hi_we/lo_we write wdata at the edge, only when IDLE and start=0. They are ignored while busy, and ignored when start=1 in the same cycle (start wins).
- hi and lo hold their values at all other times.

Optional Feature:
- Macro: MULDIV_DIVIDE_EN.
- Defined: divide datapath is compiled in, as described above.
- Undefined: divide logic is removed. In IDLE, start with op_div=1 is ignored: state stays IDLE, busy=0, no done, hi/lo unchanged. Multiply and mthi/mtlo are unaffected.

Decomposition:
- Package muldiv_pkg holds:
  - state enum IDLE/RUN/FIN;
  - localparams OP_MULT/OP_DIV and OP_UNSIGNED/OP_SIGNED;
  - DIV0_QUOTIENT constant (all ones).
- One sub-module, muldiv_signfix: combinational absolute-value on entry and conditional negation of the product, quotient and remainder on exit. It is shared by the multiply and divide paths.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF, start at cycle 0 -> busy cycles 1–33, done at cycle 34, hi=0xFFFFFFFE lo=0x00000001.
- MULT a=-3 b=5 -> hi=0xFFFFFFFF lo=0xFFFFFFF1; back-to-back MULTU 7×6 with start in the done cycle -> lo=42 hi=0, 33 cycles later.
- (MULDIV_DIVIDE_EN) DIVU 100/7 -> lo=14 hi=2; DIV -7/2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF; DIVU 5/0 -> lo=0xFFFFFFFF hi=5.
- start pulsed again at cycle 5 with different operands -> ignored; result matches the first operation.
- hi_we with wdata=0x1234 during busy -> hi unchanged; same write in IDLE -> hi=0x1234 next cycle.
- reset asserted at cycle 10 of a MULT -> next cycle busy=0 hi=lo=0, no done pulse ever; new start afterwards completes normally.
